// File: rtl/btr_pkg.sv
// btr_pkg: shared FSM state type, default word width and the combinational bit-reverse helper.
package btr_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int WIDTH_DEFAULT = 16;

    function automatic logic [WIDTH_DEFAULT-1:0] btr_f(input logic [WIDTH_DEFAULT-1:0] w);
        for (int i = 0; i < WIDTH_DEFAULT; i++) btr_f[i] = w[WIDTH_DEFAULT-1-i];
    endfunction

endpackage

// File: rtl/btr_place.sv
// btr_place: drops beat c at stream offset c*B, mapped to word[k] (rev) or word[WIDTH-1-k] (natural).
module btr_place #(
    parameter int WIDTH = 16,
    parameter int B     = 1,
    parameter int CW    = 5
) (
    input  logic [B-1:0]     i_bits,
    input  logic [CW-1:0]    i_cnt,
    input  logic             i_rev,
    output logic [WIDTH-1:0] o_val
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [IW-1:0] w_idx;
    int            w_k;

    always_comb begin
        o_val = '0;
        w_idx = '0;
        w_k   = 0;
        for (int j = 0; j < B; j++) begin
            w_k = int'(i_cnt) * B + j;
            if (w_k < WIDTH) begin
                w_idx        = i_rev ? IW'(w_k) : IW'(WIDTH - 1 - w_k);
                o_val[w_idx] = i_bits[j];
            end
        end
    end

endmodule

// File: rtl/btr_deser.sv
// btr_deser: assembles B-bit stream beats into one WIDTH-bit word, natural or bit-reversed, with valid/ready output.
module btr_deser
    import btr_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int B     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [B-1:0]     in_bits,
    input  logic             rev,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic             busy
);
    localparam int NB = WIDTH / B;
    localparam int CW = $clog2(NB + 1);

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc, r_out, w_val, w_acc_next;
    logic             r_rev_q, w_rev, w_beat, w_last, w_flush;

    assign in_ready  = (r_state != DONE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state == SHIFT);
    assign out_word  = r_out;

    assign w_flush    = (r_state == SHIFT) && abort;
    assign w_beat     = in_valid && in_ready && !w_flush;
    assign w_last     = (r_cnt == CW'(NB - 1));
    // The first beat must be placed with the incoming rev, before rev_q is latched.
    assign w_rev      = (r_state == IDLE) ? rev : r_rev_q;
    assign w_acc_next = ((r_state == IDLE) ? '0 : r_acc) | w_val;

    btr_place #(.WIDTH(WIDTH), .B(B), .CW(CW)) u_place (
        .i_bits (in_bits),
        .i_cnt  (r_cnt),
        .i_rev  (w_rev),
        .o_val  (w_val)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_beat ? (w_last ? DONE : SHIFT) : IDLE;
            SHIFT:   w_next = w_flush ? IDLE : ((w_beat && w_last) ? DONE : SHIFT);
            DONE:    w_next = out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_rev_q <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_flush || (r_state == DONE && out_ready)) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_acc_next;
                if (r_state == IDLE) r_rev_q <= rev;
                if (w_last) r_out <= w_acc_next;
            end
        end
    end

endmodule

// File: tb/tb_btr_deser.sv
// tb_btr_deser: directed checks of btr_deser with B=1 and B=4 instances.
module tb_btr_deser;
    import btr_pkg::*;

    logic        clk, rst_n;
    logic        v1, rdy1, bits1, rev1, abort1, ov1, ordy1, busy1;
    logic [15:0] ow1;
    logic        v4, rdy4, rev4, abort4, ov4, ordy4, busy4;
    logic [3:0]  bits4;
    logic [15:0] ow4;
    int          n_chk, n_fail;

    btr_deser #(.WIDTH(16), .B(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1), .in_bits(bits1),
        .rev(rev1), .abort(abort1), .out_valid(ov1), .out_ready(ordy1), .out_word(ow1), .busy(busy1)
    );

    btr_deser #(.WIDTH(16), .B(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(rdy4), .in_bits(bits4),
        .rev(rev4), .abort(abort4), .out_valid(ov4), .out_ready(ordy4), .out_word(ow4), .busy(busy4)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic beat1(input logic b, input logic r);
        v1 = 1; bits1 = b; rev1 = r;
        @(posedge clk); #1;
        v1 = 0;
    endtask

    // MSB-first stream: beat c carries word bit 15-c
    task automatic send1(input logic [15:0] w, input logic r, input int n);
        for (int c = 0; c < n; c++) beat1(w[15-c], r);
    endtask

    task automatic beat4(input logic [3:0] b, input logic r);
        v4 = 1; bits4 = b; rev4 = r;
        @(posedge clk); #1;
        v4 = 0;
    endtask

    task automatic take1;
        ordy1 = 1;
        @(posedge clk); #1;
        ordy1 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 0;
        v1 = 0; bits1 = 0; rev1 = 0; abort1 = 0; ordy1 = 0;
        v4 = 0; bits4 = 0; rev4 = 0; abort4 = 0; ordy4 = 0;
        #3;
        check("rst_out_valid", 16'(ov1), 16'd0);
        check("rst_out_word", ow1, 16'h0000);
        check("rst_in_ready", 16'(rdy1), 16'd1);
        check("rst_busy", 16'(busy1), 16'd0);
        @(posedge clk); #1;
        rst_n = 1;

        // 1: natural order, latency
        send1(16'hA5C3, 1'b0, 15);
        check("t1_no_valid_early", 16'(ov1), 16'd0);
        check("t1_busy", 16'(busy1), 16'd1);
        beat1(1'b1, 1'b0);
        check("t1_valid", 16'(ov1), 16'd1);
        check("t1_word", ow1, 16'hA5C3);
        check("t1_in_ready_done", 16'(rdy1), 16'd0);
        check("t1_busy_done", 16'(busy1), 16'd0);
        take1;
        check("t1_idle_valid", 16'(ov1), 16'd0);
        check("t1_idle_ready", 16'(rdy1), 16'd1);

        // 2: reversed
        send1(16'hA5C3, 1'b1, 16);
        check("t2_word", ow1, 16'hC3A5);
        check("t2_word_btr_f", ow1, btr_f(16'hA5C3));

        // 3: backpressure with beats offered in DONE
        for (int i = 0; i < 5; i++) begin
            v1 = 1; bits1 = 0; rev1 = 0;
            @(posedge clk); #1;
            check("t3_hold_valid", 16'(ov1), 16'd1);
            check("t3_hold_word", ow1, 16'hC3A5);
            check("t3_in_ready", 16'(rdy1), 16'd0);
        end
        v1 = 0;
        take1;
        check("t3_release_idle", 16'(ov1), 16'd0);
        check("t3_release_busy", 16'(busy1), 16'd0);
        send1(16'h0F0F, 1'b0, 16);
        check("t3_next_word", ow1, 16'h0F0F);
        take1;

        // 4: abort after 7 beats, beat in the abort cycle dropped
        send1(16'hFFFF, 1'b0, 7);
        abort1 = 1; v1 = 1; bits1 = 1;
        @(posedge clk); #1;
        abort1 = 0; v1 = 0;
        check("t4_abort_busy", 16'(busy1), 16'd0);
        check("t4_abort_ready", 16'(rdy1), 16'd1);
        check("t4_abort_keeps_out", ow1, 16'h0F0F);
        send1(16'h0001, 1'b1, 16);
        check("t4_word", ow1, 16'h8000);
        abort1 = 1;
        @(posedge clk); #1;
        abort1 = 0;
        check("t4_abort_in_done", 16'(ov1), 16'd1);
        take1;

        // 5: async reset mid-word and in DONE
        send1(16'hFFFF, 1'b0, 9);
        #2 rst_n = 0;
        #1;
        check("t5_mid_busy", 16'(busy1), 16'd0);
        check("t5_mid_word", ow1, 16'h0000);
        check("t5_mid_ready", 16'(rdy1), 16'd1);
        #1 rst_n = 1;
        send1(16'h5AA5, 1'b0, 16);
        check("t5_done_before", 16'(ov1), 16'd1);
        #2 rst_n = 0;
        #1;
        check("t5_done_valid", 16'(ov1), 16'd0);
        check("t5_done_word", ow1, 16'h0000);
        #1 rst_n = 1;
        send1(16'h1234, 1'b0, 16);
        check("t5_next_word", ow1, 16'h1234);
        take1;

        // 6: B=4, rev sampled on the first beat only
        beat4(4'h8, 1'b1);
        beat4(4'h4, 1'b0);
        beat4(4'hC, 1'b0);
        check("t6_no_valid_early", 16'(ov4), 16'd0);
        beat4(4'h2, 1'b1);
        check("t6_valid", 16'(ov4), 16'd1);
        check("t6_word_rev", ow4, 16'h2C48);
        check("t6_word_btr_f", ow4, btr_f(16'h1234));
        ordy4 = 1;
        @(posedge clk); #1;
        ordy4 = 0;
        beat4(4'h8, 1'b0);
        beat4(4'h4, 1'b1);
        beat4(4'hC, 1'b1);
        beat4(4'h2, 1'b1);
        check("t6_word_nat", ow4, 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
